// File: rtl/neuron_buffer_writer_if.sv
// Operand stream interface between the host/DMA producer and the neuron
// buffer writer.
//   s_valid  : beat valid (master -> slave)
//   s_ready  : writer can accept a beat (slave -> master)
//   s_weight : weight operand of the beat
//   s_x      : x operand of the beat
//   s_last   : beat closes the current operand vector
interface neuron_buffer_writer_if #(
  parameter int data_size = 32
);
  logic                 s_valid;
  logic                 s_ready;
  logic [data_size-1:0] s_weight;
  logic [data_size-1:0] s_x;
  logic                 s_last;

  modport master (
    output s_valid, s_weight, s_x, s_last,
    input  s_ready
  );

  modport slave (
    input  s_valid, s_weight, s_x, s_last,
    output s_ready
  );
endinterface

// File: rtl/neuron_buffer_writer.sv
// Ping-pong operand buffer between the operand stream and the neuron MAC.
// The stream fills one bank while the neuron reads the other; a bank closes
// on s_last or when it reaches depth entries, and is handed to the read side.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-low reset
//   s            : operand stream (slave modport)
//   bank_valid   : read bank is full and readable
//   bank_len     : entries in read bank (0 when not valid)
//   bank_release : pulse, neuron finished with read bank
//   r_en/r_addr  : read request from neuron
//   weight_out   : registered weight read data (latency 1)
//   x_out        : registered x read data (latency 1)
module neuron_buffer_writer #(
  parameter  int data_size = 32,
  parameter  int depth     = 16,
  localparam int addr_w    = $clog2(depth)
) (
  input  logic                 clk,
  input  logic                 rst,
  neuron_buffer_writer_if.slave s,
  output logic                 bank_valid,
  output logic [addr_w:0]      bank_len,
  input  logic                 bank_release,
  input  logic                 r_en,
  input  logic [addr_w-1:0]    r_addr,
  output logic [data_size-1:0] weight_out,
  output logic [data_size-1:0] x_out
);

  logic [1:0]          full_q, full_d;
  logic [addr_w:0]     len_q [2];
  logic [addr_w:0]     len_d [2];
  logic                wr_bank_q, wr_bank_d;
  logic [addr_w-1:0]   wr_addr_q, wr_addr_d;
  logic                rd_bank_q, rd_bank_d;
  logic [data_size-1:0] weight_q, weight_d;
  logic [data_size-1:0] x_q, x_d;

  // RAM contents are deliberately left out of reset.
  logic [data_size-1:0] mem_w [2][depth];
  logic [data_size-1:0] mem_x [2][depth];

  logic accept;
  logic close;
  logic release_ok;
  logic rd_hit;

  assign s.s_ready  = !full_q[wr_bank_q];
  assign accept     = s.s_valid && !full_q[wr_bank_q];
  assign close      = accept && (s.s_last || (wr_addr_q == addr_w'(depth - 1)));
  assign release_ok = bank_release && full_q[rd_bank_q];

  assign bank_valid = full_q[rd_bank_q];
  assign bank_len   = full_q[rd_bank_q] ? len_q[rd_bank_q] : '0;

  // Out-of-range addresses and reads of an empty bank return zero.
  assign rd_hit = full_q[rd_bank_q] && ({1'b0, r_addr} < len_q[rd_bank_q]);

  always_comb begin
    full_d    = full_q;
    len_d     = len_q;
    wr_bank_d = wr_bank_q;
    wr_addr_d = wr_addr_q;
    rd_bank_d = rd_bank_q;
    weight_d  = weight_q;
    x_d       = x_q;

    if (accept) begin
      wr_addr_d = wr_addr_q + addr_w'(1);
    end

    // Close and release always target different banks: a close needs the
    // write bank empty, a release needs the read bank full.
    if (close) begin
      full_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]  = {1'b0, wr_addr_q} + (addr_w + 1)'(1);
      wr_addr_d         = '0;
      wr_bank_d         = !wr_bank_q;
    end

    if (release_ok) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end

    if (r_en) begin
      if (rd_hit) begin
        weight_d = mem_w[rd_bank_q][r_addr];
        x_d      = mem_x[rd_bank_q][r_addr];
      end else begin
        weight_d = '0;
        x_d      = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q    <= '0;
      len_q[0]  <= '0;
      len_q[1]  <= '0;
      wr_bank_q <= 1'b0;
      wr_addr_q <= '0;
      rd_bank_q <= 1'b0;
      weight_q  <= '0;
      x_q       <= '0;
    end else begin
      full_q    <= full_d;
      len_q     <= len_d;
      wr_bank_q <= wr_bank_d;
      wr_addr_q <= wr_addr_d;
      rd_bank_q <= rd_bank_d;
      weight_q  <= weight_d;
      x_q       <= x_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem_w[wr_bank_q][wr_addr_q] <= s.s_weight;
      mem_x[wr_bank_q][wr_addr_q] <= s.s_x;
    end
  end

  assign weight_out = weight_q;
  assign x_out      = x_q;

endmodule
